msg_schedule_stream: RTL and testbench

MSG_SCHEDULE_STREAM -- requirements
Module: msg_schedule_stream

---
 rtl/sha_pkg.sv | 33 +++
 rtl/msg_schedule_stream_if.sv | 25 ++
 rtl/sha_sigma.sv | 27 ++
 rtl/msg_schedule_stream.sv | 102 ++++++++++
 tb/tb_msg_schedule_stream.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sha_pkg.sv
// Shared definitions for the SHA-2 message schedule stream: FSM states,
// sigma rotation/shift amounts per word width, and legal round counts.
package sha_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int ROUNDS_256 = 64;
  localparam int ROUNDS_512 = 80;

  localparam int S0_R1_32 = 7;
  localparam int S0_R2_32 = 18;
  localparam int S0_SH_32 = 3;
  localparam int S1_R1_32 = 17;
  localparam int S1_R2_32 = 19;
  localparam int S1_SH_32 = 10;

  localparam int S0_R1_64 = 1;
  localparam int S0_R2_64 = 8;
  localparam int S0_SH_64 = 7;
  localparam int S1_R1_64 = 19;
  localparam int S1_R2_64 = 61;
  localparam int S1_SH_64 = 6;

  // 80 rounds only exist for the 64-bit (SHA-512) schedule.
  function automatic bit params_legal(input int word_w, input int rounds);
    return (word_w == 32 && rounds == ROUNDS_256) ||
           (word_w == 64 && (rounds == ROUNDS_256 || rounds == ROUNDS_512));
  endfunction

endpackage

// File: rtl/msg_schedule_stream_if.sv
// Block-in / schedule-word-out bus of the message schedule stream.
interface msg_schedule_stream_if #(
  parameter int WORD_W = 32
);
  logic                   blk_valid;
  logic [16*WORD_W-1:0]   blk_data;
  logic                   blk_ready;
  logic                   abort;
  logic                   w_valid;
  logic [WORD_W-1:0]      w_data;
  logic [6:0]             w_idx;
  logic                   w_last;
  logic                   w_ready;

  // master: the schedule engine; slave: block source and word consumer.
  modport master (
    input  blk_valid, blk_data, abort, w_ready,
    output blk_ready, w_valid, w_data, w_idx, w_last
  );

  modport slave (
    output blk_valid, blk_data, abort, w_ready,
    input  blk_ready, w_valid, w_data, w_idx, w_last
  );
endinterface

// File: rtl/sha_sigma.sv
// Combinational SHA-2 small sigma functions for a 32- or 64-bit word.
module sha_sigma
  import sha_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic [WORD_W-1:0] x,
  output logic [WORD_W-1:0] s0,
  output logic [WORD_W-1:0] s1
);

  localparam int R01 = (WORD_W == 64) ? S0_R1_64 : S0_R1_32;
  localparam int R02 = (WORD_W == 64) ? S0_R2_64 : S0_R2_32;
  localparam int SH0 = (WORD_W == 64) ? S0_SH_64 : S0_SH_32;
  localparam int R11 = (WORD_W == 64) ? S1_R1_64 : S1_R1_32;
  localparam int R12 = (WORD_W == 64) ? S1_R2_64 : S1_R2_32;
  localparam int SH1 = (WORD_W == 64) ? S1_SH_64 : S1_SH_32;

  assign s0 = {x[R01-1:0], x[WORD_W-1:R01]} ^
              {x[R02-1:0], x[WORD_W-1:R02]} ^
              (x >> SH0);

  assign s1 = {x[R11-1:0], x[WORD_W-1:R11]} ^
              {x[R12-1:0], x[WORD_W-1:R12]} ^
              (x >> SH1);

endmodule

// File: rtl/msg_schedule_stream.sv
// Streams SHA-2 schedule words W_0..W_{ROUNDS-1} from a 16-word sliding
// window, one word per consumer handshake, with zero-bubble block chaining.
module msg_schedule_stream
  import sha_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int ROUNDS = 64
) (
  input  logic                  clk,
  input  logic                  n_rst,
  msg_schedule_stream_if.master bus
);

  generate
    if (!params_legal(WORD_W, ROUNDS)) begin : g_bad_params
      $error("msg_schedule_stream: illegal WORD_W/ROUNDS combination");
    end
  endgenerate

  localparam logic [6:0] LAST_IDX = 7'(ROUNDS - 1);

  state_e            state_q, state_d;
  logic [6:0]        idx_q, idx_d;
  logic [WORD_W-1:0] win_q [16];
  logic [WORD_W-1:0] win_d [16];

  logic [WORD_W-1:0] sig0_w1, sig1_w14, s1_unused, s0_unused, win_next;
  logic              running, is_last, handshake, blk_ready_int, accept;

  // Two sigma instances share one adder tree that produces the new tail word.
  sha_sigma #(.WORD_W(WORD_W)) u_sigma_w1 (
    .x  (win_q[1]),
    .s0 (sig0_w1),
    .s1 (s1_unused)
  );

  sha_sigma #(.WORD_W(WORD_W)) u_sigma_w14 (
    .x  (win_q[14]),
    .s0 (s0_unused),
    .s1 (sig1_w14)
  );

  assign win_next      = sig1_w14 + win_q[9] + sig0_w1 + win_q[0];
  assign running       = (state_q == RUN);
  assign is_last       = running && (idx_q == LAST_IDX);
  assign handshake     = running && bus.w_ready;
  assign blk_ready_int = !bus.abort && (!running || (is_last && bus.w_ready));
  assign accept        = bus.blk_valid && blk_ready_int;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      idx_q <= '0;
      for (int k = 0; k < 16; k++) win_q[k] <= '0;
    end else begin
      idx_q <= idx_d;
      for (int k = 0; k < 16; k++) win_q[k] <= win_d[k];
    end
  end

  // Abort outranks everything; a new block outranks the shift on the last word.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    win_d   = win_q;
    if (bus.abort) begin
      state_d = IDLE;
      idx_d   = '0;
    end else if (accept) begin
      for (int k = 0; k < 16; k++) begin
        win_d[k] = bus.blk_data[(15-k)*WORD_W +: WORD_W];
      end
      idx_d   = '0;
      state_d = RUN;
    end else if (handshake) begin
      for (int k = 0; k < 15; k++) win_d[k] = win_q[k+1];
      win_d[15] = win_next;
      if (is_last) begin
        state_d = IDLE;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + 7'd1;
      end
    end
  end

  always_comb begin
    bus.blk_ready = blk_ready_int;
    bus.w_valid   = running;
    bus.w_data    = win_q[0];
    bus.w_idx     = idx_q;
    bus.w_last    = is_last;
  end

endmodule

// File: tb/tb_msg_schedule_stream.sv
// Randomized self-checking bench: two engines (SHA-256 and SHA-512 shapes)
// compared against a plain-recurrence schedule model.
module tb_msg_schedule_stream;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  msg_schedule_stream_if #(.WORD_W(32)) bus32 ();
  msg_schedule_stream_if #(.WORD_W(64)) bus64 ();

  msg_schedule_stream #(.WORD_W(32), .ROUNDS(64)) dut32 (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus32.master)
  );

  msg_schedule_stream #(.WORD_W(64), .ROUNDS(80)) dut64 (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus64.master)
  );

  int checks   = 0;
  int failures = 0;

  logic [63:0] exp_w [0:79];
  logic [63:0] got_w [0:79];

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input int ww);
    logic [31:0] x32;
    if (ww == 32) begin
      x32 = x[31:0];
      return {32'b0, (x32 >> n) | (x32 << (32 - n))};
    end
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [63:0] ssig0(input logic [63:0] x, input int ww);
    if (ww == 32) return rotr(x, 7, 32) ^ rotr(x, 18, 32) ^ (x >> 3);
    return rotr(x, 1, 64) ^ rotr(x, 8, 64) ^ (x >> 7);
  endfunction

  function automatic logic [63:0] ssig1(input logic [63:0] x, input int ww);
    if (ww == 32) return rotr(x, 17, 32) ^ rotr(x, 19, 32) ^ (x >> 10);
    return rotr(x, 19, 64) ^ rotr(x, 61, 64) ^ (x >> 6);
  endfunction

  // Textbook recurrence W_t = s1(W_{t-2}) + W_{t-7} + s0(W_{t-15}) + W_{t-16}.
  task automatic compute_expected(input logic [1023:0] blk, input int ww, input int rounds);
    logic [63:0] sum;
    for (int t = 0; t < 16; t++) begin
      if (ww == 32) exp_w[t] = {32'b0, blk[(15-t)*32 +: 32]};
      else          exp_w[t] = blk[(15-t)*64 +: 64];
    end
    for (int t = 16; t < rounds; t++) begin
      sum = ssig1(exp_w[t-2], ww) + exp_w[t-7] + ssig0(exp_w[t-15], ww) + exp_w[t-16];
      exp_w[t] = (ww == 32) ? {32'b0, sum[31:0]} : sum;
    end
  endtask

  function automatic logic [1023:0] random_block(input int ww);
    logic [1023:0] b;
    b = '0;
    for (int k = 0; k < 32; k++) b[k*32 +: 32] = $urandom;
    if (ww == 32) b[1023:512] = '0;
    return b;
  endfunction

  task automatic drive(input int sel, input logic bv, input logic [1023:0] bd,
                       input logic ab, input logic wr);
    if (sel == 0) begin
      bus32.blk_valid = bv; bus32.blk_data = bd[511:0];
      bus32.abort = ab;     bus32.w_ready = wr;
    end else begin
      bus64.blk_valid = bv; bus64.blk_data = bd;
      bus64.abort = ab;     bus64.w_ready = wr;
    end
  endtask

  task automatic sample(input int sel, output logic v, output logic [63:0] d,
                        output logic [6:0] ix, output logic l, output logic br);
    if (sel == 0) begin
      v = bus32.w_valid; d = {32'b0, bus32.w_data}; ix = bus32.w_idx;
      l = bus32.w_last;  br = bus32.blk_ready;
    end else begin
      v = bus64.w_valid; d = bus64.w_data; ix = bus64.w_idx;
      l = bus64.w_last;  br = bus64.blk_ready;
    end
  endtask

  // Offer a block from IDLE and check the first word appears one cycle later.
  task automatic load_block(input int sel, input logic [1023:0] blk, input int ww,
                            input int rounds, input string name);
    logic v, l, br; logic [63:0] d; logic [6:0] ix;
    compute_expected(blk, ww, rounds);
    @(negedge clk);
    drive(sel, 1'b1, blk, 1'b0, 1'b0);
    #1; sample(sel, v, d, ix, l, br);
    checks++;
    if ({br, v} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL %s_offer: ready/valid got %b%b expected 10", name, br, v);
    end
    @(posedge clk); @(negedge clk);
    drive(sel, 1'b0, blk, 1'b0, 1'b0);
    #1; sample(sel, v, d, ix, l, br);
    checks++;
    if (v !== 1'b1 || d !== exp_w[0] || ix !== 7'd0) begin
      failures++;
      $display("[TB] FAIL %s_latency: got v=%b d=%h idx=%0d expected v=1 d=%h idx=0",
               name, v, d, ix, exp_w[0]);
    end
  endtask

  // Accept words 0..upto-1; when the whole block is taken also check the return to IDLE.
  task automatic consume(input int sel, input int upto, input int rounds,
                         input bit rnd, input string name);
    logic v, l, br, wr; logic [63:0] d; logic [6:0] ix;
    int exp_i = 0;
    int cyc = 0;
    while (exp_i < upto && cyc < 4000) begin
      wr = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      drive(sel, 1'b0, '0, 1'b0, wr);
      #1; sample(sel, v, d, ix, l, br);
      checks++;
      if (v !== 1'b1 || d !== exp_w[exp_i] || ix !== 7'(exp_i) || l !== (exp_i == rounds - 1)) begin
        failures++;
        $display("[TB] FAIL %s_word: got v=%b d=%h idx=%0d last=%b expected v=1 d=%h idx=%0d last=%b",
                 name, v, d, ix, l, exp_w[exp_i], exp_i, (exp_i == rounds - 1));
      end
      if (wr) begin
        got_w[exp_i] = d;
        exp_i++;
      end
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    if (exp_i < upto) begin
      checks++; failures++;
      $display("[TB] FAIL %s_timeout: got %0d words expected %0d", name, exp_i, upto);
    end else if (upto == rounds) begin
      drive(sel, 1'b0, '0, 1'b0, 1'b0);
      #1; sample(sel, v, d, ix, l, br);
      checks++;
      if ({v, l, br} !== 3'b001) begin
        failures++;
        $display("[TB] FAIL %s_end: valid/last/ready got %b%b%b expected 001", name, v, l, br);
      end
    end
  endtask

  task automatic test_reset();
    logic v, l, br; logic [63:0] d; logic [6:0] ix;
    n_rst = 1'b0;
    drive(0, 1'b0, '0, 1'b0, 1'b0);
    drive(1, 1'b0, '0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sample(s, v, d, ix, l, br);
      checks++;
      if (v !== 1'b0 || d !== 64'd0 || ix !== 7'd0 || l !== 1'b0) begin
        failures++;
        $display("[TB] FAIL reset_outputs%0d: got v=%b d=%h idx=%0d last=%b expected all zero",
                 s, v, d, ix, l);
      end
    end
    @(negedge clk);
    n_rst = 1'b1;
    #1;
    for (int s = 0; s < 2; s++) begin
      sample(s, v, d, ix, l, br);
      checks++;
      if (br !== 1'b1 || v !== 1'b0) begin
        failures++;
        $display("[TB] FAIL reset_release%0d: got ready=%b valid=%b expected ready=1 valid=0", s, br, v);
      end
    end
  endtask

  task automatic test_abc(input bit rnd, input string name);
    logic [1023:0] blk;
    blk = '0;
    blk[511:480] = 32'h61626380;
    blk[31:0]    = 32'h00000018;
    load_block(0, blk, 32, 64, name);
    consume(0, 64, 64, rnd, name);
    checks++;
    if (got_w[16][31:0] !== 32'h61626380 || got_w[17][31:0] !== 32'h000F0000) begin
      failures++;
      $display("[TB] FAIL %s_w16_w17: got %h %h expected 61626380 000f0000",
               name, got_w[16][31:0], got_w[17][31:0]);
    end
  endtask

  task automatic test_zero();
    load_block(0, '0, 32, 64, "zero");
    consume(0, 64, 64, 1'b0, "zero");
  endtask

  task automatic test_back_to_back();
    logic v, l, br; logic [63:0] d; logic [6:0] ix;
    logic [1023:0] blk_b;
    load_block(0, random_block(32), 32, 64, "b2b_a");
    consume(0, 63, 64, 1'b1, "b2b_a");
    blk_b = random_block(32);
    drive(0, 1'b1, blk_b, 1'b0, 1'b1);
    #1; sample(0, v, d, ix, l, br);
    checks++;
    if (v !== 1'b1 || l !== 1'b1 || br !== 1'b1 || ix !== 7'd63 || d !== exp_w[63]) begin
      failures++;
      $display("[TB] FAIL b2b_last: got v=%b last=%b ready=%b idx=%0d d=%h expected 1 1 1 63 %h",
               v, l, br, ix, d, exp_w[63]);
    end
    @(posedge clk); @(negedge clk);
    compute_expected(blk_b, 32, 64);
    drive(0, 1'b0, '0, 1'b0, 1'b0);
    #1; sample(0, v, d, ix, l, br);
    checks++;
    if (v !== 1'b1 || ix !== 7'd0 || d !== exp_w[0]) begin
      failures++;
      $display("[TB] FAIL b2b_first: got v=%b idx=%0d d=%h expected v=1 idx=0 d=%h", v, ix, d, exp_w[0]);
    end
    consume(0, 64, 64, 1'b0, "b2b_b");
  endtask

  task automatic test_abort();
    logic v, l, br; logic [63:0] d; logic [6:0] ix;
    load_block(0, random_block(32), 32, 64, "abort");
    consume(0, 20, 64, 1'b1, "abort");
    drive(0, 1'b1, random_block(32), 1'b1, 1'($urandom_range(0, 1)));
    #1; sample(0, v, d, ix, l, br);
    checks++;
    if (br !== 1'b0 || v !== 1'b1 || ix !== 7'd20) begin
      failures++;
      $display("[TB] FAIL abort_cycle: got ready=%b valid=%b idx=%0d expected 0 1 20", br, v, ix);
    end
    @(posedge clk); @(negedge clk);
    drive(0, 1'b0, '0, 1'b0, 1'b1);
    #1; sample(0, v, d, ix, l, br);
    checks++;
    if (v !== 1'b0 || ix !== 7'd0 || br !== 1'b1) begin
      failures++;
      $display("[TB] FAIL abort_after: got valid=%b idx=%0d ready=%b expected 0 0 1", v, ix, br);
    end
    repeat (3) @(posedge clk);
    #1; sample(0, v, d, ix, l, br);
    checks++;
    if (v !== 1'b0) begin
      failures++;
      $display("[TB] FAIL abort_quiet: got valid=%b expected 0", v);
    end
    load_block(0, random_block(32), 32, 64, "abort_next");
    consume(0, 64, 64, 1'b0, "abort_next");
  endtask

  task automatic test_reset_mid_block();
    logic v, l, br; logic [63:0] d; logic [6:0] ix;
    load_block(0, random_block(32), 32, 64, "rstmid");
    consume(0, 30, 64, 1'b0, "rstmid");
    drive(0, 1'b0, '0, 1'b0, 1'b1);
    n_rst = 1'b0;
    #1; sample(0, v, d, ix, l, br);
    checks++;
    if (v !== 1'b0 || d !== 64'd0 || ix !== 7'd0 || l !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rstmid_asserted: got v=%b d=%h idx=%0d last=%b expected zeros", v, d, ix, l);
    end
    @(negedge clk);
    n_rst = 1'b1;
    repeat (3) @(posedge clk);
    #1; sample(0, v, d, ix, l, br);
    checks++;
    if (v !== 1'b0 || br !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rstmid_release: got valid=%b ready=%b expected 0 1", v, br);
    end
    load_block(0, random_block(32), 32, 64, "rstmid_next");
    consume(0, 64, 64, 1'b1, "rstmid_next");
  endtask

  task automatic test_sha512();
    logic [1023:0] blk;
    blk = '0;
    blk[1023:960] = 64'd1;
    load_block(1, blk, 64, 80, "sha512");
    consume(1, 80, 80, 1'b0, "sha512");
    checks++;
    if (got_w[16] !== 64'd1 || got_w[17] !== 64'd0 || got_w[18] !== 64'h0000200000000008) begin
      failures++;
      $display("[TB] FAIL sha512_w16_18: got %h %h %h expected 1 0 0000200000000008",
               got_w[16], got_w[17], got_w[18]);
    end
    load_block(1, random_block(64), 64, 80, "sha512_rand");
    consume(1, 80, 80, 1'b1, "sha512_rand");
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_abc(1'b0, "abc");
    test_zero();
    test_abc(1'b1, "abc_bp");
    test_back_to_back();
    test_abort();
    test_reset_mid_block();
    test_sha512();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
